hazard_ctrl: RTL

- Hazard and stall controller for the 5-stage pipeline; it drives the bubble-insert stall input of the ID/EX register.
- Watches the EX-stage destination, MemRead and RegWrite fields, the MEM-stage load, and the ID-stage source registers, branch and jump flags.
- Generates the ID/EX bubble, the PC and IF/ID hold, and the IF/ID flush.
- Contains a small FSM that covers the 2-cycle load-to-branch case without re-evaluating the hazard.

---
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: ID/EX bubble, PC and IF/ID hold, IF/ID flush.
// Optional saturating stall/flush cycle counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             ID_JumpReg,
  input  logic [4:0]       EX_Write_register,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       MEM_Write_register,
  input  logic             MEM_MemRead,
  output logic             IDEX_stall,
  output logic             PC_hold,
  output logic             IFID_hold,
  output logic             IFID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_m_ex;
  logic       w_m_mem;
  logic       w_ctl;
  logic [1:0] w_need;
  logic       w_stall;
  logic       w_redirect;
  logic       w_stall_out;
  logic       w_flush_out;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  assign w_m_ex  = (EX_Write_register != 5'd0) &&
                   ((EX_Write_register == ID_Rs) ||
                    (ID_UsesRt && (EX_Write_register == ID_Rt)));
  assign w_m_mem = (MEM_Write_register != 5'd0) &&
                   ((MEM_Write_register == ID_Rs) ||
                    (ID_UsesRt && (MEM_Write_register == ID_Rt)));

  // Branches and jr/jalr resolve in ID, so they need operands one stage earlier than the ALU.
  assign w_ctl = ID_Branch || ID_JumpReg;

  always_comb begin
    w_need = 2'd0;
    if (w_ctl && EX_MemRead && w_m_ex) begin
      w_need = 2'd2;
    end else if ((!w_ctl && EX_MemRead && w_m_ex) ||
                 (w_ctl && EX_RegWrite && !EX_MemRead && w_m_ex) ||
                 (w_ctl && MEM_MemRead && w_m_mem)) begin
      w_need = 2'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      RUN: begin
        w_stall = (w_need != 2'd0);
        if (w_need == 2'd2) w_state_nxt = HOLD;
      end
      HOLD: begin
        // Second load-to-branch bubble; the hazard is not re-evaluated here.
        w_stall     = 1'b1;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Outputs are Mealy and gated by reset so an abort in HOLD takes effect immediately.
  assign w_redirect  = (ID_Branch && ID_BranchTaken) || ID_Jump || ID_JumpReg;
  assign w_stall_out = w_stall && !reset;
  assign w_flush_out = !w_stall && w_redirect && !reset;

  assign IDEX_stall = w_stall_out;
  assign PC_hold    = w_stall_out;
  assign IFID_hold  = w_stall_out;
  assign IFID_flush = w_flush_out;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_out && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_out && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule
